// File: rtl/vm_change_dispenser.sv
// Change dispenser: pays a requested amount one coin at a time to a hopper,
// greedy largest-first within per-tube inventory, reporting any unpaid residue.
module vm_change_dispenser #(
  parameter int AMT_W      = 11,
  parameter int CNT_W      = 8,
  parameter int INIT_COUNT = 20
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic             coin_ack,
  input  logic             refill,
  output logic             busy,
  output logic             coin_req,
  output logic [2:0]       coin_sel,
  output logic             done,
  output logic [AMT_W-1:0] shortfall,
  output logic [4:0]       empty
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SELECT   = 2'd1,
    S_DISPENSE = 2'd2,
    S_FINISH   = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [AMT_W-1:0]        remaining_q, remaining_d;
  logic [AMT_W-1:0]        shortfall_q, shortfall_d;
  logic [2:0]              sel_q, sel_d;
  logic [4:0][CNT_W-1:0]   count_q, count_d;
  logic                    busy_q, busy_d;
  logic                    coin_req_q, coin_req_d;
  logic                    done_q, done_d;
  logic [4:0]              empty_q, empty_d;
  logic                    pick_found_s;
  logic [2:0]              pick_idx_s;

  function automatic logic [AMT_W-1:0] coin_value(input logic [2:0] idx);
    logic [AMT_W-1:0] v;
    case (idx)
      3'd0:    v = AMT_W'(7'd100);
      3'd1:    v = AMT_W'(7'd50);
      3'd2:    v = AMT_W'(7'd25);
      3'd3:    v = AMT_W'(7'd10);
      3'd4:    v = AMT_W'(7'd5);
      default: v = '0;
    endcase
    return v;
  endfunction

  // Greedy pick: scanning from the smallest coin up lets the largest usable coin win.
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if ((count_q[i] != '0) && (coin_value(3'(i)) <= remaining_q)) begin
        pick_found_s = 1'b1;
        pick_idx_s   = 3'(i);
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    shortfall_d = shortfall_q;
    sel_d       = sel_q;
    count_d     = count_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          remaining_d = amount;
          shortfall_d = '0;
          state_d     = S_SELECT;
        end else if (refill) begin
          count_d = {5{CNT_W'(INIT_COUNT)}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SELECT: begin
        if (pick_found_s) begin
          sel_d   = pick_idx_s;
          state_d = S_DISPENSE;
        end else begin
          shortfall_d = remaining_q;
          state_d     = S_FINISH;
        end
      end
      S_DISPENSE: begin
        if (coin_ack) begin
          remaining_d = remaining_q - coin_value(sel_q);
          for (int i = 0; i < 5; i++) begin
            if (3'(i) == sel_q) begin
              count_d[i] = count_q[i] - CNT_W'(1);
            end else begin
              count_d[i] = count_q[i];
            end
          end
          state_d = S_SELECT;
        end else begin
          state_d = S_DISPENSE;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    busy_d     = (state_d != S_IDLE);
    coin_req_d = (state_d == S_DISPENSE);
    done_d     = (state_d == S_FINISH);
    for (int i = 0; i < 5; i++) begin
      empty_d[i] = (count_d[i] == '0);
    end
  end

  // State and output registers; reset abandons any request in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      shortfall_q <= '0;
      sel_q       <= 3'd0;
      count_q     <= {5{CNT_W'(INIT_COUNT)}};
      busy_q      <= 1'b0;
      coin_req_q  <= 1'b0;
      done_q      <= 1'b0;
      empty_q     <= 5'b00000;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      shortfall_q <= shortfall_d;
      sel_q       <= sel_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      coin_req_q  <= coin_req_d;
      done_q      <= done_d;
      empty_q     <= empty_d;
    end
  end

  assign busy      = busy_q;
  assign coin_req  = coin_req_q;
  assign coin_sel  = sel_q;
  assign done      = done_q;
  assign shortfall = shortfall_q;
  assign empty     = empty_q;

endmodule
